// File: rtl/simd_mac_pkg.sv
// -----------------------------------------------------------------------------
// simd_mac_pkg
// Shared types, constants and the saturating adder used by the SIMD MAC array.
//   PIPE_LATENCY  cycles from input accept to result valid
//   lane_mode_t   per-lane operand signedness (1 = unsigned)
//   sat_add()     width-generic add with signed/unsigned clamping and an
//                 overflow flag; operands live in the low 'width' bits of a
//                 MAX_ACC_W container, so 'width' must be below MAX_ACC_W.
// -----------------------------------------------------------------------------
package simd_mac_pkg;

  localparam int PIPE_LATENCY = 2;
  localparam int MAX_ACC_W    = 64;

  typedef struct packed {
    logic unsigned_a;
    logic unsigned_b;
  } lane_mode_t;

  typedef struct packed {
    logic [MAX_ACC_W-1:0] sum;
    logic                 ovf;
  } sat_result_t;

  function automatic sat_result_t sat_add(input logic [MAX_ACC_W-1:0] acc,
                                          input logic [MAX_ACC_W-1:0] p,
                                          input logic                 is_signed,
                                          input int                   width);
    logic [MAX_ACC_W:0] mask;
    logic [MAX_ACC_W:0] msb;
    logic [MAX_ACC_W:0] sum_full;
    logic               acc_neg;
    logic               p_neg;
    logic               sum_neg;
    sat_result_t        r;
    mask     = ((MAX_ACC_W+1)'(1) << width) - (MAX_ACC_W+1)'(1);
    msb      = (MAX_ACC_W+1)'(1) << (width - 1);
    sum_full = ({1'b0, acc} & mask) + ({1'b0, p} & mask);
    acc_neg  = |({1'b0, acc} & msb);
    p_neg    = |({1'b0, p} & msb);
    sum_neg  = |(sum_full & msb);
    r.sum    = sum_full[MAX_ACC_W-1:0] & mask[MAX_ACC_W-1:0];
    r.ovf    = 1'b0;
    if (is_signed) begin
      // Two's complement overflow: addends agree in sign, the sum does not.
      if ((acc_neg == p_neg) && (sum_neg != acc_neg)) begin
        r.ovf = 1'b1;
        r.sum = acc_neg ? msb[MAX_ACC_W-1:0] : (msb[MAX_ACC_W-1:0] - MAX_ACC_W'(1));
      end
    end else if (|(sum_full & (msb << 1))) begin
      // Unsigned overflow: carry out of the top accumulator bit.
      r.ovf = 1'b1;
      r.sum = mask[MAX_ACC_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/simd_mac_array_lane.sv
// -----------------------------------------------------------------------------
// simd_mac_lane
// One lane: operand extension, multiply, and the stage-2 accumulator register.
// Optional saturation when SIMD_MAC_SATURATE_EN is defined.
//   clk, rst     clock and synchronous active-high reset
//   en           pipeline advance into stage 2
//   a, b         stage-1 operands
//   mode         stage-1 signedness of a and b
//   acc_en       accumulate mode
//   load_acc     restart accumulation (already gated by acc_en upstream)
//   acc          accumulator / result
//   ovf          sticky clamp flag (SIMD_MAC_SATURATE_EN only)
// -----------------------------------------------------------------------------
module simd_mac_lane
  import simd_mac_pkg::*;
#(
  parameter int A_WIDTH   = 10,
  parameter int B_WIDTH   = 9,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  lane_mode_t           mode,
  input  logic                 acc_en,
  input  logic                 load_acc,
  output logic [ACC_WIDTH-1:0] acc
`ifdef SIMD_MAC_SATURATE_EN
  ,
  output logic                 ovf
`endif
);

  // Product is computed wide enough to hold either the full product or the
  // accumulator, whichever is larger; only the low ACC_WIDTH bits are kept.
  localparam int PW = A_WIDTH + B_WIDTH + 2;
  localparam int EW = (PW > ACC_WIDTH) ? PW : ACC_WIDTH;

  logic signed [A_WIDTH:0] a_ext;
  logic signed [B_WIDTH:0] b_ext;
  logic signed [EW-1:0]    prod_full;
  logic [ACC_WIDTH-1:0]    prod;
  logic [ACC_WIDTH-1:0]    acc_next;
  logic                    restart;

  // One extra bit per operand makes zero- and sign-extension a single signed multiply.
  assign a_ext     = {~mode.unsigned_a & a[A_WIDTH-1], a};
  assign b_ext     = {~mode.unsigned_b & b[B_WIDTH-1], b};
  assign prod_full = EW'(a_ext) * EW'(b_ext);
  assign prod      = prod_full[ACC_WIDTH-1:0];
  assign restart   = ~acc_en | load_acc;

`ifdef SIMD_MAC_SATURATE_EN
  sat_result_t sr;
  logic        is_signed;
  logic        sat_unused;

  assign is_signed  = ~(mode.unsigned_a & mode.unsigned_b);
  assign sr         = sat_add(MAX_ACC_W'(acc), MAX_ACC_W'(prod), is_signed, ACC_WIDTH);
  assign acc_next   = sr.sum[ACC_WIDTH-1:0];
  assign sat_unused = ^sr.sum[MAX_ACC_W-1:ACC_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (en) begin
      if (acc_en & load_acc) begin
        ovf <= 1'b0;
      end else if (~restart & sr.ovf) begin
        ovf <= 1'b1;
      end
    end
  end
`else
  assign acc_next = acc + prod;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= restart ? prod : acc_next;
    end
  end

endmodule

// File: rtl/simd_mac_array.sv
// -----------------------------------------------------------------------------
// simd_mac_array
// N-lane SIMD multiply-accumulate with a 2-stage valid/ready pipeline.
// Stage 1 captures operands and mode bits; stage 2 is the per-lane
// accumulator, which drives z_o directly.
// Optional feature macro: SIMD_MAC_SATURATE_EN (saturating accumulate, ovf_o).
//   clock_i, reset_i         clock, synchronous active-high reset
//   valid_i / ready_o        input handshake
//   a_i, b_i                 packed lane operands
//   unsigned_a_i/_b_i        per-lane signedness (1 = unsigned)
//   acc_en_i, load_acc_i     accumulate mode, restart accumulation
//   valid_o / ready_i        output handshake
//   z_o                      packed lane results
//   ovf_o                    sticky per-lane clamp flag (macro only)
// -----------------------------------------------------------------------------
module simd_mac_array
  import simd_mac_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int A_WIDTH   = 10,
  parameter int B_WIDTH   = 9,
  parameter int ACC_WIDTH = 24
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [NUM_CH*A_WIDTH-1:0]     a_i,
  input  logic [NUM_CH*B_WIDTH-1:0]     b_i,
  input  logic [NUM_CH-1:0]             unsigned_a_i,
  input  logic [NUM_CH-1:0]             unsigned_b_i,
  input  logic                          acc_en_i,
  input  logic                          load_acc_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [NUM_CH*ACC_WIDTH-1:0]   z_o
`ifdef SIMD_MAC_SATURATE_EN
  ,
  output logic [NUM_CH-1:0]             ovf_o
`endif
);

  logic                      s1_valid;
  logic [NUM_CH*A_WIDTH-1:0] s1_a;
  logic [NUM_CH*B_WIDTH-1:0] s1_b;
  logic [NUM_CH-1:0]         s1_ua;
  logic [NUM_CH-1:0]         s1_ub;
  logic                      s1_acc_en;
  logic                      s1_load;
  logic                      adv2;
  logic                      accept;

  // Stage 2 moves when it is empty or being drained; stage 1 can refill in
  // the same cycle it empties, so there is no bubble at full throughput.
  assign adv2    = s1_valid & (~valid_o | ready_i);
  // NOTE: ready_o is combinational on ready_i so a full pipe keeps 1 beat/cycle.
  assign ready_o = ~s1_valid | adv2;
  assign accept  = valid_i & ready_o;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      s1_valid <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end
      if (adv2) begin
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  // NOTE: stage-1 payload is not reset; s1_valid alone qualifies it.
  always_ff @(posedge clock_i) begin
    if (accept) begin
      s1_a      <= a_i;
      s1_b      <= b_i;
      s1_ua     <= unsigned_a_i;
      s1_ub     <= unsigned_b_i;
      s1_acc_en <= acc_en_i;
      s1_load   <= load_acc_i & acc_en_i;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    lane_mode_t mode;
    assign mode = '{unsigned_a: s1_ua[k], unsigned_b: s1_ub[k]};

    simd_mac_lane #(
      .A_WIDTH  (A_WIDTH),
      .B_WIDTH  (B_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk     (clock_i),
      .rst     (reset_i),
      .en      (adv2),
      .a       (s1_a[k*A_WIDTH +: A_WIDTH]),
      .b       (s1_b[k*B_WIDTH +: B_WIDTH]),
      .mode    (mode),
      .acc_en  (s1_acc_en),
      .load_acc(s1_load),
      .acc     (z_o[k*ACC_WIDTH +: ACC_WIDTH])
`ifdef SIMD_MAC_SATURATE_EN
      ,
      .ovf     (ovf_o[k])
`endif
    );
  end

endmodule

// File: tb/tb_simd_mac_array.sv
// -----------------------------------------------------------------------------
// tb_simd_mac_array
// Self-checking bench for simd_mac_array (NUM_CH=2, A=10, B=9, ACC=20).
// A behavioural model computes every lane result from integer arithmetic at
// accept time and queues it; outputs are compared in order as they drain.
// Honours SIMD_MAC_SATURATE_EN for clamping and ovf_o.
// -----------------------------------------------------------------------------
module tb_simd_mac_array;

  localparam int     NC    = 2;
  localparam int     AW    = 10;
  localparam int     BW    = 9;
  localparam int     ZW    = 20;
  localparam longint ZMOD  = longint'(1) << ZW;
  localparam longint MAX_S = (longint'(1) << (ZW-1)) - 1;
  localparam longint MIN_S = -(longint'(1) << (ZW-1));

  logic              clock_i = 1'b0;
  logic              reset_i;
  logic              valid_i;
  logic              ready_o;
  logic [NC*AW-1:0]  a_i;
  logic [NC*BW-1:0]  b_i;
  logic [NC-1:0]     unsigned_a_i;
  logic [NC-1:0]     unsigned_b_i;
  logic              acc_en_i;
  logic              load_acc_i;
  logic              valid_o;
  logic              ready_i;
  logic [NC*ZW-1:0]  z_o;
`ifdef SIMD_MAC_SATURATE_EN
  logic [NC-1:0]     ovf_o;
`endif

  simd_mac_array #(.NUM_CH(NC), .A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(ZW)) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .unsigned_a_i(unsigned_a_i),
    .unsigned_b_i(unsigned_b_i),
    .acc_en_i    (acc_en_i),
    .load_acc_i  (load_acc_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .z_o         (z_o)
`ifdef SIMD_MAC_SATURATE_EN
    ,
    .ovf_o       (ovf_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [NC*ZW-1:0] z;
    logic [NC-1:0]    ovf;
    int               cyc;
  } exp_t;

  exp_t          exp_q[$];
  longint        model_acc[NC];
  logic [NC-1:0] model_ovf;
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;

  // Observations from the most recent cycle.
  logic             obs_accept, obs_fire, obs_ready, obs_valid;
  logic [NC*ZW-1:0] obs_z;
  logic [NC-1:0]    obs_ovf;
  exp_t             obs_exp;

  // Pending beat for the stream loops.
  logic [NC*AW-1:0] na;
  logic [NC*BW-1:0] nb;
  logic [NC-1:0]    nua, nub;
  logic             nae, nld;

  function automatic longint lane_val(input longint raw, input int w, input logic is_u);
    if (is_u || raw < (longint'(1) << (w-1))) return raw;
    return raw - (longint'(1) << w);
  endfunction

  function automatic longint wrap(input longint x);
    return ((x % ZMOD) + ZMOD) % ZMOD;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    for (int k = 0; k < NC; k++) model_acc[k] = 0;
    model_ovf = '0;
  endtask

  task automatic model_accept(input logic [NC*AW-1:0] a, input logic [NC*BW-1:0] b,
                              input logic [NC-1:0] ua, input logic [NC-1:0] ub,
                              input logic ae, input logic ld);
    exp_t e;
    for (int k = 0; k < NC; k++) begin
      longint p, sum;
      logic   sgn;
      p   = lane_val(longint'(a[k*AW +: AW]), AW, ua[k]) * lane_val(longint'(b[k*BW +: BW]), BW, ub[k]);
      sgn = !(ua[k] && ub[k]);
      if (!ae || ld) begin
        sum = p;
        if (ae) model_ovf[k] = 1'b0;
      end else begin
        sum = lane_val(model_acc[k], ZW, !sgn) + p;
`ifdef SIMD_MAC_SATURATE_EN
        if (sgn && sum > MAX_S)       begin sum = MAX_S;    model_ovf[k] = 1'b1; end
        else if (sgn && sum < MIN_S)  begin sum = MIN_S;    model_ovf[k] = 1'b1; end
        else if (!sgn && sum >= ZMOD) begin sum = ZMOD - 1; model_ovf[k] = 1'b1; end
`endif
      end
      model_acc[k] = wrap(sum);
      e.z[k*ZW +: ZW] = model_acc[k][ZW-1:0];
    end
    e.ovf = model_ovf;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Drive one cycle at the falling edge, then record what the DUT shows.
  task automatic run_cycle(input logic v, input logic [NC*AW-1:0] a, input logic [NC*BW-1:0] b,
                           input logic [NC-1:0] ua, input logic [NC-1:0] ub,
                           input logic ae, input logic ld, input logic rdy);
    @(negedge clock_i);
    valid_i = v; a_i = a; b_i = b; unsigned_a_i = ua; unsigned_b_i = ub;
    acc_en_i = ae; load_acc_i = ld; ready_i = rdy;
    #1;
    obs_ready  = ready_o;
    obs_valid  = valid_o;
    obs_accept = v && ready_o;
    obs_fire   = valid_o && rdy;
    obs_z      = z_o;
`ifdef SIMD_MAC_SATURATE_EN
    obs_ovf    = ovf_o;
`else
    obs_ovf    = '0;
`endif
    obs_exp = '{z: 'x, ovf: 'x, cyc: -100};
    if (obs_fire && exp_q.size() > 0) obs_exp = exp_q.pop_front();
    if (obs_accept) model_accept(a, b, ua, ub, ae, ld);
    cyc++;
  endtask

  task automatic rand_beat(input logic ae, input int ld_pct);
    na  = (NC*AW)'($urandom);
    nb  = (NC*BW)'($urandom);
    nua = NC'($urandom);
    nub = NC'($urandom);
    nae = ae;
    nld = ae && ($urandom_range(0, 99) < ld_pct);
  endtask

  task automatic test_reset();
    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; a_i = '0; b_i = '0;
    unsigned_a_i = '0; unsigned_b_i = '0; acc_en_i = 1'b0; load_acc_i = 1'b0;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
    model_clear();
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (z_o !== '0) begin errors++; $display("FAIL reset_z: got %h want 0", z_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
`ifdef SIMD_MAC_SATURATE_EN
    checks++; if (ovf_o !== '0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
`endif
  endtask

  task automatic test_plain_multiply();
    int sent = 0, got = 0;
    na = {10'd1023, 10'd5}; nb = {9'd511, 9'd7}; nua = 2'b11; nub = 2'b11; nae = 1'b0; nld = 1'b0;
    for (int c = 0; c < 40 && !(sent == 6 && exp_q.size() == 0); c++) begin
      run_cycle(sent < 6, na, nb, nua, nub, nae, nld, 1'b1);
      if (obs_accept) begin sent++; rand_beat(1'b0, 0); end
      if (obs_fire) begin
        checks++;
        if (obs_z !== obs_exp.z) begin errors++; $display("FAIL plain_z[%0d]: got %h want %h", got, obs_z, obs_exp.z); end
        checks++;
        if ((cyc - 1) - obs_exp.cyc != 2) begin errors++; $display("FAIL plain_latency[%0d]: got %0d want 2", got, (cyc - 1) - obs_exp.cyc); end
        if (got == 0) begin
          checks++;
          if (obs_z !== {20'd522753, 20'd35}) begin errors++; $display("FAIL plain_first: got %h want %h", obs_z, {20'd522753, 20'd35}); end
        end
        got++;
      end
    end
    checks++; if (sent != 6 || got != 6) begin errors++; $display("FAIL plain_count: got %0d/%0d want 6/6", sent, got); end
  endtask

  task automatic test_signed_accumulate();
    int av[3] = '{-3, 2, -1};
    int bv[3] = '{4, 5, 1};
    int z0[3] = '{-12, -2, -3};
    int sent = 0, got = 0;
    for (int c = 0; c < 30 && !(sent == 3 && exp_q.size() == 0); c++) begin
      int i;
      i = (sent < 3) ? sent : 2;
      run_cycle(sent < 3, {10'd1, AW'(av[i])}, {9'd1, BW'(bv[i])}, 2'b10, 2'b10, 1'b1, i == 0, 1'b1);
      if (obs_accept) sent++;
      if (obs_fire) begin
        logic [ZW-1:0] ev;
        ev = ZW'(z0[got]);
        checks++;
        if (obs_z !== obs_exp.z) begin errors++; $display("FAIL sacc_z[%0d]: got %h want %h", got, obs_z, obs_exp.z); end
        checks++;
        if (obs_z[ZW-1:0] !== ev) begin errors++; $display("FAIL sacc_lane0[%0d]: got %h want %h", got, obs_z[ZW-1:0], ev); end
        got++;
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL sacc_count: got %0d want 3", got); end
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0, stall_checks = 0;
    longint sum0 = 0;
    logic [NC*ZW-1:0] prev_z = '0, last_z = '0;
    logic prev_stall = 1'b0;
    for (int c = 0; c < 60 && !(sent == 4 && exp_q.size() == 0); c++) begin
      logic rdy;
      int   n_before;
      if (c == 0 || obs_accept) begin
        rand_beat(1'b1, 0);
        nld = (sent == 0);
        nua = 2'b00; nub = 2'b00;
      end
      rdy = !(c >= 2 && c < 7);
      run_cycle(sent < 4, na, nb, nua, nub, nae, nld, rdy);
      if (obs_accept) begin
        sum0 += lane_val(longint'(na[AW-1:0]), AW, 1'b0) * lane_val(longint'(nb[BW-1:0]), BW, 1'b0);
        sent++;
      end
      n_before = exp_q.size() - (obs_accept ? 1 : 0) + (obs_fire ? 1 : 0);
      if (prev_stall) begin
        checks++;
        if (obs_z !== prev_z || obs_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got %h/%b want %h/1", obs_z, obs_valid, prev_z); end
      end
      if (obs_valid && !rdy && n_before >= 2) begin
        stall_checks++; checks++;
        if (obs_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", obs_ready); end
      end
      if (obs_fire) begin
        checks++;
        if (obs_z !== obs_exp.z) begin errors++; $display("FAIL bp_z[%0d]: got %h want %h", got, obs_z, obs_exp.z); end
        last_z = obs_z;
        got++;
      end
      prev_stall = obs_valid && !rdy;
      prev_z = obs_z;
    end
    checks++; if (got != 4 || sent != 4) begin errors++; $display("FAIL bp_count: got %0d/%0d want 4/4", sent, got); end
    checks++; if (stall_checks == 0) begin errors++; $display("FAIL bp_fill: got 0 full-stall cycles want >0"); end
    checks++;
    if (last_z[ZW-1:0] !== wrap(sum0)) begin errors++; $display("FAIL bp_sum: got %h want %h", last_z[ZW-1:0], wrap(sum0)); end
  endtask

  task automatic test_mixed_lanes();
    int got = 0;
    logic sent = 1'b0;
    for (int c = 0; c < 20 && !(sent && exp_q.size() == 0); c++) begin
      run_cycle(!sent, {10'd512, 10'd512}, {9'd256, 9'd256}, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1);
      if (obs_accept) sent = 1'b1;
      if (obs_fire) begin
        checks++;
        if (obs_z !== obs_exp.z) begin errors++; $display("FAIL mixed_model: got %h want %h", obs_z, obs_exp.z); end
        checks++;
        if (obs_z !== {20'd131072, 20'd131072}) begin errors++; $display("FAIL mixed_const: got %h want %h", obs_z, {20'd131072, 20'd131072}); end
        got++;
      end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL mixed_count: got %0d want 1", got); end
  endtask

  task automatic test_reset_mid();
    int got = 0;
    logic sent = 1'b0;
    rand_beat(1'b1, 100);
    run_cycle(1'b1, na, nb, nua, nub, 1'b1, 1'b1, 1'b1);
    rand_beat(1'b1, 0);
    run_cycle(1'b1, na, nb, nua, nub, 1'b1, 1'b0, 1'b1);
    @(negedge clock_i);
    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clock_i);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", valid_o); end
    checks++; if (z_o !== '0) begin errors++; $display("FAIL rmid_z: got %h want 0", z_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", ready_o); end
    @(negedge clock_i);
    reset_i = 1'b0;
    model_clear();
    for (int c = 0; c < 20 && !(sent && exp_q.size() == 0); c++) begin
      run_cycle(!sent, {10'd2, 10'd3}, {9'd2, 9'd3}, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1);
      if (obs_accept) sent = 1'b1;
      if (obs_fire) begin
        checks++;
        if (obs_z !== {20'd4, 20'd9}) begin errors++; $display("FAIL rmid_load: got %h want %h", obs_z, {20'd4, 20'd9}); end
        got++;
      end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL rmid_count: got %0d want 1", got); end
  endtask

  task automatic test_saturate();
    int sent = 0, got = 0;
`ifdef SIMD_MAC_SATURATE_EN
    logic [NC*ZW-1:0] want7 = {20'd1048575, 20'd524287};
`else
    logic [NC*ZW-1:0] want7 = {20'd513543, 20'd912135};
`endif
    for (int c = 0; c < 40 && !(sent == 8 && exp_q.size() == 0); c++) begin
      if (sent < 7) run_cycle(1'b1, {10'd1023, 10'd511}, {9'd511, 9'd255}, 2'b10, 2'b10, 1'b1, sent == 0, 1'b1);
      else          run_cycle(sent < 8, {10'd1, 10'd1}, {9'd1, 9'd1}, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1);
      if (obs_accept) sent++;
      if (obs_fire) begin
        checks++;
        if (obs_z !== obs_exp.z) begin errors++; $display("FAIL sat_z[%0d]: got %h want %h", got, obs_z, obs_exp.z); end
        if (got == 6) begin
          checks++;
          if (obs_z !== want7) begin errors++; $display("FAIL sat_final: got %h want %h", obs_z, want7); end
        end
`ifdef SIMD_MAC_SATURATE_EN
        checks++;
        if (obs_ovf !== obs_exp.ovf) begin errors++; $display("FAIL sat_ovf[%0d]: got %b want %b", got, obs_ovf, obs_exp.ovf); end
        if (got == 6) begin
          checks++;
          if (obs_ovf !== 2'b11) begin errors++; $display("FAIL sat_ovf_set: got %b want 11", obs_ovf); end
        end
`endif
        got++;
      end
    end
    checks++; if (got != 8) begin errors++; $display("FAIL sat_count: got %0d want 8", got); end
  endtask

  task automatic test_random();
    int sent = 0, got = 0;
    rand_beat($urandom_range(0, 1) == 1, 25);
    for (int c = 0; c < 1000 && !(sent == 80 && exp_q.size() == 0); c++) begin
      logic v;
      v = (sent < 80) && ($urandom_range(0, 4) != 0);
      run_cycle(v, na, nb, nua, nub, nae, nld, $urandom_range(0, 3) != 0);
      if (obs_accept) begin sent++; rand_beat($urandom_range(0, 1) == 1, 25); end
      if (obs_fire) begin
        checks++;
        if (obs_z !== obs_exp.z) begin errors++; $display("FAIL rand_z[%0d]: got %h want %h", got, obs_z, obs_exp.z); end
`ifdef SIMD_MAC_SATURATE_EN
        checks++;
        if (obs_ovf !== obs_exp.ovf) begin errors++; $display("FAIL rand_ovf[%0d]: got %b want %b", got, obs_ovf, obs_exp.ovf); end
`endif
        got++;
      end
    end
    checks++; if (sent != 80 || got != 80) begin errors++; $display("FAIL rand_count: got %0d/%0d want 80/80", sent, got); end
  endtask

  initial begin
    test_reset();
    test_plain_multiply();
    test_signed_accumulate();
    test_backpressure();
    test_mixed_lanes();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
